zsdram_wr_responder: RTL and testbench
======================================

# zsdram_wr_responder

Responder end of the 4-word SDRAM write-request handshake used by the draw path. It accepts one request (24-bit address plus four 16-bit pixel words), converts it into a single 4-beat write burst towards the SDRAM controller core, and returns a one-cycle done pulse to the requester. It sits between the draw pipeline's SDRAM glue outputs and the SDRAM controller.

## Interface
- TIMEOUT_CYCLES, 1024, burst watchdog limit in clk cycles; used only with ZSDRAM_WR_TIMEOUT_EN.
- clk  input  1  system clock; all logic is on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- en  input  1  block enable; low forces IDLE next edge, outputs return to reset values; counters and flags are held.
- iSDRAM_Wr_Req  input  1  write request; held high by the requester until it sees done.
- iSDRAM_Wr_Addr  input  24  Bank(2)+Row(13)+Column(9).
- iSDRAM_Wr_Data1..iSDRAM_Wr_Data4  input  16 each  beats 0..3.
- oSDRAM_Wr_Done  output  1  one-cycle done pulse.
- oBurst_Req  output  1  burst command request to the controller.
- iBurst_Ack  input  1  controller accepted the command.
- oBurst_Addr  output  24  burst start address.
- iBurst_Data_Req  input  1  controller consumes the current beat this cycle.
- oBurst_Data  output  16  current beat data.
- iBurst_Done  input  1  controller finished the burst.
- oBusy  output  1  high in every state except IDLE.
- oWr_Count  output  16  completed requests; wraps from 16'hFFFF to 0.
- oErr  output  1  sticky protocol/alignment error; cleared only by reset.

## Operation
- States: IDLE, CMD, DATA, WAIT_DONE, ACK, RELEASE.
- IDLE:
  - When iSDRAM_Wr_Req=1, latch the address and the four data words.
  - Go to CMD.
- Address handling:
  - oBurst_Addr = {addr[23:2], 2'b00}.
  - If addr[1:0] is not 0, set oErr. The burst still executes at the aligned address.
- CMD:
  - oBurst_Req=1 until iBurst_Ack is sampled high, then go to DATA with the beat index at 0.
  - oBurst_Req drops on the same edge.
- DATA:
  - oBurst_Data = latched word[beat].
  - Each cycle with iBurst_Data_Req=1 advances the beat.
  - After beat 3 is consumed, go to WAIT_DONE.
  - iBurst_Data_Req is ignored in all other states.
- WAIT_DONE: iBurst_Done=1 -> ACK.
- Early iBurst_Done:
  - If iBurst_Done=1 is sampled in DATA before beat 3 is consumed, set oErr and go to ACK.
  - If it is sampled in the same cycle that beat 3 is consumed, go to ACK without an error.
- ACK:
  - oSDRAM_Wr_Done=1 for exactly one cycle.
  - oWr_Count increments.
  - Go to RELEASE.
- RELEASE:
  - Wait until iSDRAM_Wr_Req=0, then go to IDLE.
  - This guarantees one request is never serviced twice, because the requester drops Req one cycle after seeing done.
- Latched data is stable from IDLE exit to ACK; requester input changes during a burst are ignored.

## Timing
- Reset values (rst_n=0 at an edge):
  - state IDLE.
  - oSDRAM_Wr_Done, oBurst_Req and oBusy = 0.
  - oBurst_Addr and oBurst_Data = 0.
  - oWr_Count and oErr = 0.
- All outputs are registered except oBurst_Data, which is a mux of registered words.
- Latency, with the request sampled at edge 0:
  - oBurst_Req is high after edge 1.
  - With immediate ack, four back-to-back data requests and done on the cycle after the last beat, oSDRAM_Wr_Done is high after edge 7.
  - Minimum request-to-request spacing is 9 cycles: RELEASE needs Req low, then IDLE samples the new request.
- Reset or en=0 mid-burst:
  - Abandon immediately and go to IDLE; no done pulse; the count is unchanged.
  - The controller must tolerate the dropped request.
- The index wraps only via its terminal condition; no beat beyond 3 is ever presented.

## Configuration
- ZSDRAM_WR_TIMEOUT_EN defined:
  - A watchdog counts cycles spent in CMD, DATA and WAIT_DONE.
  - When the count reaches TIMEOUT_CYCLES, set oErr and go to ACK; the done pulse is issued and the count still increments, so the requester never hangs.
  - The watchdog clears on IDLE exit.
- Not defined: no watchdog logic. The block waits indefinitely for the controller, and TIMEOUT_CYCLES is unused.

## Test plan
- Single write: addr=24'h000010, data 16'hF800/07E0/001F/FFFF, ack and data_req always 1, done after the 4th beat. Required: oBurst_Data shows the words in order, done pulses 1 cycle at edge 7, oWr_Count=1, oErr=0.
- Held request: Req held high for 3 cycles after done. Required: exactly one burst and oWr_Count=1; the next burst starts only after a Req low/high cycle.
- Stalled controller: ack delayed 5 cycles, data_req toggling 1,0,1,0,... Required: every beat is presented until consumed, no beat is skipped or repeated, and done still arrives.
- Misaligned address: addr=24'h000013. Required: oBurst_Addr=24'h000010, oErr=1 and sticky; the write completes.
- Abort: rst_n=0 during DATA beat 2. Required: all outputs reach reset values the next edge, no done pulse; the next request runs normally.
- Watchdog (macro on, TIMEOUT_CYCLES=16): iBurst_Done never asserted. Required: oErr=1 and done pulse after the 16-cycle timeout; with the macro off, the block stays in WAIT_DONE.

Source files
------------

// File: rtl/zsdram_wr_responder_if.sv
// Request/burst handshake bundle between the draw-path SDRAM glue, the write
// responder and the SDRAM controller core.
interface zsdram_wr_responder_if;
  logic        iSDRAM_Wr_Req;
  logic [23:0] iSDRAM_Wr_Addr;
  logic [15:0] iSDRAM_Wr_Data1;
  logic [15:0] iSDRAM_Wr_Data2;
  logic [15:0] iSDRAM_Wr_Data3;
  logic [15:0] iSDRAM_Wr_Data4;
  logic        oSDRAM_Wr_Done;
  logic        oBurst_Req;
  logic        iBurst_Ack;
  logic [23:0] oBurst_Addr;
  logic        iBurst_Data_Req;
  logic [15:0] oBurst_Data;
  logic        iBurst_Done;
  logic        oBusy;
  logic [15:0] oWr_Count;
  logic        oErr;

  modport slave (
    input  iSDRAM_Wr_Req, iSDRAM_Wr_Addr,
    input  iSDRAM_Wr_Data1, iSDRAM_Wr_Data2, iSDRAM_Wr_Data3, iSDRAM_Wr_Data4,
    input  iBurst_Ack, iBurst_Data_Req, iBurst_Done,
    output oSDRAM_Wr_Done, oBurst_Req, oBurst_Addr, oBurst_Data,
    output oBusy, oWr_Count, oErr
  );

  modport master (
    output iSDRAM_Wr_Req, iSDRAM_Wr_Addr,
    output iSDRAM_Wr_Data1, iSDRAM_Wr_Data2, iSDRAM_Wr_Data3, iSDRAM_Wr_Data4,
    output iBurst_Ack, iBurst_Data_Req, iBurst_Done,
    input  oSDRAM_Wr_Done, oBurst_Req, oBurst_Addr, oBurst_Data,
    input  oBusy, oWr_Count, oErr
  );
endinterface

// File: rtl/zsdram_wr_responder.sv
// Converts one 4-word write request into a single 4-beat SDRAM burst and returns
// a one-cycle done pulse. Optional burst watchdog: ZSDRAM_WR_TIMEOUT_EN.
module zsdram_wr_responder #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  zsdram_wr_responder_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, CMD, DATA, WAIT_DONE, ACK, RELEASE} state_e;

  state_e      state_q, state_d;
  logic [1:0]  beat_q, beat_d;
  logic [15:0] word_q [4];
  logic [15:0] word_d [4];
  logic [23:0] addr_q, addr_d;
  logic        req_q, req_d;
  logic        done_q, done_d;
  logic        busy_q, busy_d;
  logic [15:0] cnt_q, cnt_d;
  logic        err_q, err_d;
  logic        timeout;

`ifdef ZSDRAM_WR_TIMEOUT_EN
  localparam int unsigned WDW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WDW-1:0] wd_q, wd_d;
  logic           in_flight;

  assign in_flight = (state_q == CMD) || (state_q == DATA) || (state_q == WAIT_DONE);
  assign timeout   = en && in_flight && (wd_q == WDW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    wd_d = wd_q;
    if (state_q == IDLE)
      wd_d = '0;
    else if (en && in_flight)
      wd_d = wd_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) wd_q <= '0;
    else        wd_q <= wd_d;
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    word_d  = word_q;
    addr_d  = addr_q;
    req_d   = 1'b0;
    cnt_d   = cnt_q;
    err_d   = err_q;

    case (state_q)
      IDLE: begin
        if (bus.iSDRAM_Wr_Req) begin
          word_d[0] = bus.iSDRAM_Wr_Data1;
          word_d[1] = bus.iSDRAM_Wr_Data2;
          word_d[2] = bus.iSDRAM_Wr_Data3;
          word_d[3] = bus.iSDRAM_Wr_Data4;
          addr_d    = {bus.iSDRAM_Wr_Addr[23:2], 2'b00};
          if (bus.iSDRAM_Wr_Addr[1:0] != 2'b00) err_d = 1'b1;
          state_d   = CMD;
        end
      end
      CMD: begin
        // Ack only counts once the registered request is actually visible.
        if (req_q && bus.iBurst_Ack) begin
          state_d = DATA;
          beat_d  = '0;
        end else begin
          req_d = 1'b1;
        end
      end
      DATA: begin
        if (bus.iBurst_Data_Req) begin
          beat_d = beat_q + 2'd1;
          if (beat_q == 2'd3) state_d = WAIT_DONE;
        end
        if (bus.iBurst_Done) begin
          state_d = ACK;
          if (!(bus.iBurst_Data_Req && beat_q == 2'd3)) err_d = 1'b1;
        end
      end
      WAIT_DONE: if (bus.iBurst_Done) state_d = ACK;
      ACK:       state_d = RELEASE;
      RELEASE:   if (!bus.iSDRAM_Wr_Req) state_d = IDLE;
      default:   state_d = IDLE;
    endcase

    if (timeout) begin
      state_d = ACK;
      err_d   = 1'b1;
      req_d   = 1'b0;
    end

    if (state_d == ACK) cnt_d = cnt_q + 16'd1;
    done_d = (state_d == ACK);
    busy_d = (state_d != IDLE);

    if (!en) begin
      state_d = IDLE;
      req_d   = 1'b0;
      done_d  = 1'b0;
      busy_d  = 1'b0;
      addr_d  = '0;
      cnt_d   = cnt_q;
      err_d   = err_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      beat_q  <= '0;
      word_q  <= '{default: '0};
      addr_q  <= '0;
      req_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      word_q  <= word_d;
      addr_q  <= addr_d;
      req_q   <= req_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign bus.oSDRAM_Wr_Done = done_q;
  assign bus.oBurst_Req     = req_q;
  assign bus.oBurst_Addr    = addr_q;
  assign bus.oBurst_Data    = (state_q == DATA) ? word_q[beat_q] : '0;
  assign bus.oBusy          = busy_q;
  assign bus.oWr_Count      = cnt_q;
  assign bus.oErr           = err_q;

endmodule

// File: tb/tb_zsdram_wr_responder.sv
// Directed bench for zsdram_wr_responder: cycle table for the basic write plus
// hand sequences for stalls, errors, abort and the watchdog.
module tb_zsdram_wr_responder;

  logic clk;
  logic rst_n;
  logic en;
  int   n_chk;
  int   n_fail;

  zsdram_wr_responder_if bus ();

  zsdram_wr_responder #(.TIMEOUT_CYCLES(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n, en, req, ack, dreq, bdone;
    logic        x_done, x_breq, x_busy;
    logic [15:0] x_data;
    logic [23:0] x_addr;
    logic [15:0] x_cnt;
    logic        x_err;
  } vec_t;

  vec_t tbl [14];

  function automatic vec_t mk(input logic r, e, q, a, d, bd,
                              input logic xd, xr, xb, input logic [15:0] xdat,
                              input logic [23:0] xa, input logic [15:0] xc,
                              input logic xe);
    vec_t v;
    v.rst_n = r; v.en = e; v.req = q; v.ack = a; v.dreq = d; v.bdone = bd;
    v.x_done = xd; v.x_breq = xr; v.x_busy = xb; v.x_data = xdat;
    v.x_addr = xa; v.x_cnt = xc; v.x_err = xe;
    return v;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_words(input logic [23:0] a, input logic [15:0] w0, w1, w2, w3);
    bus.iSDRAM_Wr_Addr  = a;
    bus.iSDRAM_Wr_Data1 = w0;
    bus.iSDRAM_Wr_Data2 = w1;
    bus.iSDRAM_Wr_Data3 = w2;
    bus.iSDRAM_Wr_Data4 = w3;
  endtask

  // Fast-path burst; done_beat 0..3 raises iBurst_Done while that beat is
  // consumed, 4 raises it the cycle after the last beat.
  task automatic quick_burst(input string tag, input logic [23:0] a, input int done_beat);
    logic [15:0] w [4];
    w[0] = 16'hA000 ^ a[15:0]; w[1] = 16'hB001; w[2] = 16'hC002; w[3] = 16'hD003;
    set_words(a, w[0], w[1], w[2], w[3]);
    bus.iSDRAM_Wr_Req = 1'b1; bus.iBurst_Ack = 1'b1;
    bus.iBurst_Data_Req = 1'b1; bus.iBurst_Done = 1'b0;
    tick; tick;
    check({tag, ".addr"}, bus.oBurst_Addr, {a[23:2], 2'b00});
    tick;
    for (int b = 0; b < 4; b++) begin
      check($sformatf("%s.beat%0d", tag, b), bus.oBurst_Data, w[b]);
      if (b == done_beat) bus.iBurst_Done = 1'b1;
      tick;
      if (b == done_beat) break;
    end
    if (done_beat == 4) begin
      bus.iBurst_Done = 1'b1;
      tick;
    end
    check({tag, ".done"}, bus.oSDRAM_Wr_Done, 1'b1);
    bus.iBurst_Done = 1'b0; bus.iSDRAM_Wr_Req = 1'b0;
    tick;
    check({tag, ".pulse"}, bus.oSDRAM_Wr_Done, 1'b0);
    tick;
    check({tag, ".idle"}, bus.oBusy, 1'b0);
  endtask

  initial begin
    logic [15:0] sw [4];
    int k;
    int seen;
    n_chk = 0;
    n_fail = 0;
    rst_n = 1'b0;
    en = 1'b1;
    bus.iSDRAM_Wr_Req = 1'b0; bus.iBurst_Ack = 1'b0;
    bus.iBurst_Data_Req = 1'b0; bus.iBurst_Done = 1'b0;
    set_words(24'h000010, 16'hF800, 16'h07E0, 16'h001F, 16'hFFFF);

    // rst en req ack dreq bdone | done breq busy data addr cnt err
    tbl[0]  = mk(0,1,0,0,0,0, 0,0,0,16'h0000,24'h000000,16'd0,0);
    tbl[1]  = mk(1,1,1,1,1,0, 0,0,1,16'h0000,24'h000010,16'd0,0);
    tbl[2]  = mk(1,1,1,1,1,0, 0,1,1,16'h0000,24'h000010,16'd0,0);
    tbl[3]  = mk(1,1,1,1,1,0, 0,0,1,16'hF800,24'h000010,16'd0,0);
    tbl[4]  = mk(1,1,1,1,1,0, 0,0,1,16'h07E0,24'h000010,16'd0,0);
    tbl[5]  = mk(1,1,1,1,1,0, 0,0,1,16'h001F,24'h000010,16'd0,0);
    tbl[6]  = mk(1,1,1,1,1,0, 0,0,1,16'hFFFF,24'h000010,16'd0,0);
    tbl[7]  = mk(1,1,1,1,1,0, 0,0,1,16'h0000,24'h000010,16'd0,0);
    tbl[8]  = mk(1,1,1,1,1,1, 1,0,1,16'h0000,24'h000010,16'd1,0);
    tbl[9]  = mk(1,1,1,1,1,0, 0,0,1,16'h0000,24'h000010,16'd1,0);
    tbl[10] = mk(1,1,1,1,1,0, 0,0,1,16'h0000,24'h000010,16'd1,0);
    tbl[11] = mk(1,1,1,1,1,0, 0,0,1,16'h0000,24'h000010,16'd1,0);
    tbl[12] = mk(1,1,0,1,1,0, 0,0,0,16'h0000,24'h000010,16'd1,0);
    tbl[13] = mk(1,1,0,1,1,0, 0,0,0,16'h0000,24'h000010,16'd1,0);

    for (int i = 0; i < 14; i++) begin
      rst_n = tbl[i].rst_n; en = tbl[i].en;
      bus.iSDRAM_Wr_Req = tbl[i].req; bus.iBurst_Ack = tbl[i].ack;
      bus.iBurst_Data_Req = tbl[i].dreq; bus.iBurst_Done = tbl[i].bdone;
      tick;
      check($sformatf("vec%0d.done", i), bus.oSDRAM_Wr_Done, tbl[i].x_done);
      check($sformatf("vec%0d.breq", i), bus.oBurst_Req, tbl[i].x_breq);
      check($sformatf("vec%0d.busy", i), bus.oBusy, tbl[i].x_busy);
      check($sformatf("vec%0d.data", i), bus.oBurst_Data, tbl[i].x_data);
      check($sformatf("vec%0d.addr", i), bus.oBurst_Addr, tbl[i].x_addr);
      check($sformatf("vec%0d.cnt", i), bus.oWr_Count, tbl[i].x_cnt);
      check($sformatf("vec%0d.err", i), bus.oErr, tbl[i].x_err);
    end

    // Stalled controller: late ack, data requests every other cycle.
    sw[0] = 16'h1111; sw[1] = 16'h2222; sw[2] = 16'h3333; sw[3] = 16'h4444;
    set_words(24'h0ABC40, sw[0], sw[1], sw[2], sw[3]);
    bus.iSDRAM_Wr_Req = 1'b1; bus.iBurst_Ack = 1'b0;
    bus.iBurst_Data_Req = 1'b0; bus.iBurst_Done = 1'b0;
    tick;
    check("stall.busy", bus.oBusy, 1'b1);
    for (int c = 0; c < 5; c++) begin
      tick;
      check($sformatf("stall.breq%0d", c), bus.oBurst_Req, 1'b1);
    end
    bus.iBurst_Ack = 1'b1;
    tick;
    bus.iBurst_Ack = 1'b0;
    check("stall.breq_drop", bus.oBurst_Req, 1'b0);
    check("stall.addr", bus.oBurst_Addr, 24'h0ABC40);
    k = 0;
    for (int c = 0; c < 20 && k < 4; c++) begin
      bus.iBurst_Data_Req = (c % 2 == 0);
      check($sformatf("stall.data_c%0d", c), bus.oBurst_Data, sw[k]);
      tick;
      if (bus.iBurst_Data_Req) k++;
    end
    check("stall.beats", k, 4);
    bus.iBurst_Data_Req = 1'b0;
    bus.iBurst_Done = 1'b1;
    seen = 0;
    for (int c = 0; c < 6 && seen == 0; c++) begin
      tick;
      if (bus.oSDRAM_Wr_Done) seen = 1;
    end
    check("stall.done_seen", seen, 1);
    bus.iBurst_Done = 1'b0;
    tick;
    check("stall.pulse", bus.oSDRAM_Wr_Done, 1'b0);
    check("stall.cnt", bus.oWr_Count, 16'd2);
    check("stall.err", bus.oErr, 1'b0);
    bus.iSDRAM_Wr_Req = 1'b0;
    tick;
    check("stall.idle", bus.oBusy, 1'b0);

    // Misaligned address: aligned burst, sticky error.
    quick_burst("mis", 24'h000013, 4);
    check("mis.err", bus.oErr, 1'b1);
    check("mis.cnt", bus.oWr_Count, 16'd3);
    tick; tick;
    check("mis.sticky", bus.oErr, 1'b1);

    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    check("rst.err", bus.oErr, 1'b0);
    check("rst.cnt", bus.oWr_Count, 16'd0);

    // Done together with the last beat is legal; done mid-data is not.
    quick_burst("late3", 24'h000100, 3);
    check("late3.err", bus.oErr, 1'b0);
    check("late3.cnt", bus.oWr_Count, 16'd1);
    quick_burst("early1", 24'h000200, 1);
    check("early1.err", bus.oErr, 1'b1);
    check("early1.cnt", bus.oWr_Count, 16'd2);

    // Reset during beat 2 abandons the burst.
    set_words(24'h000400, 16'h0101, 16'h0202, 16'h0303, 16'h0404);
    bus.iSDRAM_Wr_Req = 1'b1; bus.iBurst_Ack = 1'b1; bus.iBurst_Data_Req = 1'b1;
    tick; tick; tick; tick; tick;
    check("abort.beat2", bus.oBurst_Data, 16'h0303);
    rst_n = 1'b0;
    tick;
    check("abort.done", bus.oSDRAM_Wr_Done, 1'b0);
    check("abort.breq", bus.oBurst_Req, 1'b0);
    check("abort.busy", bus.oBusy, 1'b0);
    check("abort.addr", bus.oBurst_Addr, 24'h0);
    check("abort.data", bus.oBurst_Data, 16'h0);
    check("abort.cnt", bus.oWr_Count, 16'd0);
    check("abort.err", bus.oErr, 1'b0);
    rst_n = 1'b1; bus.iSDRAM_Wr_Req = 1'b0;
    tick;
    check("abort.nodone", bus.oSDRAM_Wr_Done, 1'b0);
    quick_burst("after", 24'h000800, 4);
    check("after.cnt", bus.oWr_Count, 16'd1);
    check("after.err", bus.oErr, 1'b0);

    // en low mid-burst: back to idle, counters and flags held.
    bus.iSDRAM_Wr_Req = 1'b1; bus.iBurst_Ack = 1'b1; bus.iBurst_Data_Req = 1'b1;
    tick; tick; tick; tick;
    en = 1'b0;
    tick;
    check("en.busy", bus.oBusy, 1'b0);
    check("en.breq", bus.oBurst_Req, 1'b0);
    check("en.addr", bus.oBurst_Addr, 24'h0);
    check("en.data", bus.oBurst_Data, 16'h0);
    check("en.cnt", bus.oWr_Count, 16'd1);
    en = 1'b1; bus.iSDRAM_Wr_Req = 1'b0;
    tick;
    check("en.idle", bus.oBusy, 1'b0);

    // Controller never signals done.
    bus.iSDRAM_Wr_Req = 1'b1; bus.iBurst_Ack = 1'b1;
    bus.iBurst_Data_Req = 1'b1; bus.iBurst_Done = 1'b0;
    tick;
    seen = 0;
    for (int c = 1; c <= 40 && seen == 0; c++) begin
      tick;
      if (bus.oSDRAM_Wr_Done) seen = c;
    end
`ifdef ZSDRAM_WR_TIMEOUT_EN
    check("wd.done_at", seen, 16);
    check("wd.err", bus.oErr, 1'b1);
    check("wd.cnt", bus.oWr_Count, 16'd2);
`else
    check("wd.no_done", seen, 0);
    check("wd.busy", bus.oBusy, 1'b1);
    check("wd.cnt", bus.oWr_Count, 16'd1);
`endif
    bus.iSDRAM_Wr_Req = 1'b0;
    en = 1'b0;
    tick;
    en = 1'b1;
    tick;
    check("wd.idle", bus.oBusy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
